// File: rtl/out_buf_pkg.sv
// Shared types and constants for the tile output buffer (out_buf_router).
package out_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10
  } buf_state_t;

  localparam int ELEM_W_DEF = 16;
  localparam int LANES_DEF  = 4;

  localparam logic SRC_SA  = 1'b0;
  localparam logic SRC_BN  = 1'b1;
  localparam logic DST_INP = 1'b0;
  localparam logic DST_WP  = 1'b1;

endpackage

// File: rtl/out_buf_router_if.sv
// Bundle of source rows, drain handshakes, phase selects and status for
// out_buf_router. The slave modport is the buffer's view; master is the
// surrounding phase controller / producers / consumers.
interface out_buf_router_if #(
  parameter int ELEM_W = out_buf_pkg::ELEM_W_DEF,
  parameter int LANES  = out_buf_pkg::LANES_DEF,
  parameter int CNT_W  = 5
);
  localparam int ROW_W = LANES * ELEM_W;

  logic             buf_input_select;
  logic             buf_output_select;
  logic             sa_valid;
  logic [ROW_W-1:0] sa_data;
  logic             bn_valid;
  logic [ROW_W-1:0] bn_data;
  logic             wr_last;
  logic             inp_valid;
  logic [ROW_W-1:0] inp_data;
  logic             inp_ready;
  logic             wp_valid;
  logic [ROW_W-1:0] wp_data;
  logic             wp_ready;
  logic             buf_busy;
  logic [CNT_W-1:0] word_count;
  logic             overflow_err;

  modport slave (
    input  buf_input_select, buf_output_select,
    input  sa_valid, sa_data, bn_valid, bn_data, wr_last,
    input  inp_ready, wp_ready,
    output inp_valid, inp_data, wp_valid, wp_data,
    output buf_busy, word_count, overflow_err
  );

  modport master (
    output buf_input_select, buf_output_select,
    output sa_valid, sa_data, bn_valid, bn_data, wr_last,
    output inp_ready, wp_ready,
    input  inp_valid, inp_data, wp_valid, wp_data,
    input  buf_busy, word_count, overflow_err
  );

endinterface

// File: rtl/out_buf_mem.sv
// Row storage for the tile buffer: one synchronous write port and one
// combinational read port. No reset: contents are only meaningful once written.
module out_buf_mem #(
  parameter int ROW_W = 64,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem [DEPTH];

  // Store one row per accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_buf_router.sv
// Single-buffered tile output buffer between the SA/BN producers and the
// input/weight prefetchers. Captures one tile (FILL), then drains it (DRAIN).
// Optional macro OUT_BUF_RELU_EN: rows from the BN source get per-lane ReLU
// before storage; SA rows are always stored bit-exact.
module out_buf_router
  import out_buf_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  out_buf_router_if.slave   bus
);

  localparam int ROW_W = LANES * ELEM_W;
  localparam int PTR_W = $clog2(DEPTH);

  buf_state_t       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             in_sel_q;
  logic             out_sel_q;
  logic             overflow_q;

  logic             eff_sel;
  logic             wr;
  logic [ROW_W-1:0] src_row;
  logic [ROW_W-1:0] store_row;
  logic             full;
  logic             accept;
  logic             drop;
  logic             rd_valid;
  logic             rd_ready;
  logic             pop;
  logic [ROW_W-1:0] rd_row;

`ifdef OUT_BUF_RELU_EN
  // Clamp every negative signed lane to zero.
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0]         res;
    logic signed [ELEM_W-1:0] lane;
    res = row;
    for (int l = 0; l < LANES; l++) begin
      lane = row[l*ELEM_W +: ELEM_W];
      if (lane < 0) res[l*ELEM_W +: ELEM_W] = '0;
    end
    return res;
  endfunction
`endif

  // The first row of a tile arrives in IDLE, before in_sel_q is latched,
  // so the live select is used there; afterwards the latched one rules.
  assign eff_sel = (state == IDLE) ? bus.buf_input_select : in_sel_q;
  assign wr      = (eff_sel == SRC_BN) ? bus.bn_valid : bus.sa_valid;
  assign src_row = (eff_sel == SRC_BN) ? bus.bn_data  : bus.sa_data;

`ifdef OUT_BUF_RELU_EN
  assign store_row = (eff_sel == SRC_BN) ? relu_row(src_row) : src_row;
`else
  assign store_row = src_row;
`endif

  // Producers have no back-pressure: anything not accepted is lost and flagged.
  assign full   = (count == CNT_W'(DEPTH));
  assign accept = wr && (state != DRAIN) && !full;
  assign drop   = wr && !accept;

  assign rd_valid = (state == DRAIN) && (count != '0);
  assign rd_ready = (out_sel_q == DST_WP) ? bus.wp_ready : bus.inp_ready;
  assign pop      = rd_valid && rd_ready;

  out_buf_mem #(
    .ROW_W (ROW_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (store_row),
    .raddr (rd_ptr),
    .rdata (rd_row)
  );

  // Phase FSM with ring pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_sel_q   <= SRC_SA;
      out_sel_q  <= DST_INP;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept)   count <= count + 1'b1;
      else if (pop) count <= count - 1'b1;
      if (drop) overflow_q <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            in_sel_q <= bus.buf_input_select;
            if (bus.wr_last) begin
              out_sel_q <= bus.buf_output_select;
              state     <= DRAIN;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.wr_last || (accept && count == CNT_W'(DEPTH - 1))) begin
            out_sel_q <= bus.buf_output_select;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && count == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inp_valid    = rd_valid && (out_sel_q == DST_INP);
  assign bus.wp_valid     = rd_valid && (out_sel_q == DST_WP);
  assign bus.inp_data     = bus.inp_valid ? rd_row : '0;
  assign bus.wp_data      = bus.wp_valid  ? rd_row : '0;
  assign bus.buf_busy     = (state != IDLE);
  assign bus.word_count   = count;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_out_buf_router.sv
// Self-checking bench for out_buf_router: per-cycle comparison against a
// queue-based tile model, a table-driven SA tile, directed corner sequences
// and a randomized run.
module tb_out_buf_router;

  localparam int ELEM_W = 16;
  localparam int LANES  = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int ROW_W  = LANES * ELEM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_buf_router_if #(.ELEM_W(ELEM_W), .LANES(LANES), .CNT_W(CNT_W)) ifc ();

  out_buf_router #(.ELEM_W(ELEM_W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the tile is a queue of rows plus phase flags.
  logic [ROW_W-1:0] m_q[$];
  bit m_fill, m_drain, m_in_sel, m_out_sel, m_ovf;
  logic [ROW_W-1:0] got[$];
  bit wp_seen;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] relu_model(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] r;
    r = row;
    for (int l = 0; l < LANES; l++)
      if ($signed(row[l*ELEM_W +: ELEM_W]) < 0) r[l*ELEM_W +: ELEM_W] = '0;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fill = 0; m_drain = 0; m_in_sel = 0; m_out_sel = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit sel, wr, rdy;
    logic [ROW_W-1:0] row;
    sel = (!m_fill && !m_drain) ? ifc.buf_input_select : m_in_sel;
    wr  = sel ? ifc.bn_valid : ifc.sa_valid;
    row = sel ? ifc.bn_data : ifc.sa_data;
`ifdef OUT_BUF_RELU_EN
    if (sel) row = relu_model(row);
`endif
    if (m_drain) begin
      if (wr) m_ovf = 1;
      rdy = m_out_sel ? ifc.wp_ready : ifc.inp_ready;
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_drain = 0;
      end
    end else if (!m_fill) begin
      if (wr) begin
        m_q.push_back(row);
        m_in_sel = sel;
        if (ifc.wr_last) begin
          m_drain = 1; m_out_sel = ifc.buf_output_select;
        end else m_fill = 1;
      end
    end else begin
      if (wr) begin
        if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back(row);
      end
      if (ifc.wr_last || m_q.size() == DEPTH) begin
        m_fill = 0; m_drain = 1; m_out_sel = ifc.buf_output_select;
      end
    end
  endtask

  task automatic model_check();
    bit v;
    logic [ROW_W-1:0] d;
    v = m_drain && (m_q.size() > 0);
    d = v ? m_q[0] : '0;
    chk("inp_valid",    ifc.inp_valid,    v && !m_out_sel);
    chk("inp_data",     ifc.inp_data,     (v && !m_out_sel) ? d : '0);
    chk("wp_valid",     ifc.wp_valid,     v && m_out_sel);
    chk("wp_data",      ifc.wp_data,      (v && m_out_sel) ? d : '0);
    chk("buf_busy",     ifc.buf_busy,     m_fill || m_drain);
    chk("word_count",   ifc.word_count,   ROW_W'(m_q.size()));
    chk("overflow_err", ifc.overflow_err, m_ovf);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    model_check();
    if (ifc.inp_valid && ifc.inp_ready) got.push_back(ifc.inp_data);
    if (ifc.wp_valid  && ifc.wp_ready)  got.push_back(ifc.wp_data);
    if (ifc.wp_valid) wp_seen = 1;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ifc.sa_valid = 0; ifc.bn_valid = 0; ifc.wr_last = 0;
  endtask

  task automatic drain_all(input bit rdy_inp, input bit rdy_wp);
    ifc.inp_ready = rdy_inp; ifc.wp_ready = rdy_wp;
    for (int k = 0; k < 64 && ifc.buf_busy; k++) cycle();
    chk("drain_timeout", ifc.buf_busy, 1'b0);
  endtask

  typedef struct {
    logic             sa_v;
    logic [ROW_W-1:0] sa_d;
    logic             bn_v;
    logic             last;
    logic             e_inp_v;
    logic [ROW_W-1:0] e_inp_d;
    logic             e_wp_v;
    logic             e_busy;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tv[7];
  logic [ROW_W-1:0] rA, rB, rC, relu_in, relu_exp, prev_d;
  bit prev_stall;
  bit [4:0] stall_pat;

  initial begin
    rA = 64'h0001_0002_0003_0004;
    rB = 64'h0011_0022_0033_0044;
    rC = 64'h8111_7222_F333_0444;
    //        sa_v sa_d bn_v last | inp_v inp_d wp_v busy cnt
    tv[0] = '{1'b1, rA, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd0};
    tv[1] = '{1'b1, rB, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 5'd1};
    tv[2] = '{1'b1, rC, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 5'd2};
    tv[3] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, rA, 1'b0, 1'b1, 5'd3};
    tv[4] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, rB, 1'b0, 1'b1, 5'd2};
    tv[5] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, rC, 1'b0, 1'b1, 5'd1};
    tv[6] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd0};

    ifc.buf_input_select = 0; ifc.buf_output_select = 0;
    ifc.sa_data = '0; ifc.bn_data = '0; idle_in();
    ifc.inp_ready = 0; ifc.wp_ready = 0;
    model_reset();
    wp_seen = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy", ifc.buf_busy, 1'b0);
    chk("rst_count", ifc.word_count, '0);
    chk("rst_ovf", ifc.overflow_err, 1'b0);
    chk("rst_inp_valid", ifc.inp_valid, 1'b0);
    chk("rst_wp_valid", ifc.wp_valid, 1'b0);
    chk("rst_inp_data", ifc.inp_data, '0);
    rst = 0;

    // Table-driven SA tile of 3 rows to the input prefetcher
    ifc.inp_ready = 1; ifc.wp_ready = 1;
    ifc.bn_data = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 7; i++) begin
      ifc.sa_valid = tv[i].sa_v; ifc.sa_data = tv[i].sa_d;
      ifc.bn_valid = tv[i].bn_v; ifc.wr_last = tv[i].last;
      chk("tv_inp_valid", ifc.inp_valid, tv[i].e_inp_v);
      chk("tv_inp_data", ifc.inp_data, tv[i].e_inp_d);
      chk("tv_wp_valid", ifc.wp_valid, tv[i].e_wp_v);
      chk("tv_busy", ifc.buf_busy, tv[i].e_busy);
      chk("tv_count", ifc.word_count, tv[i].e_cnt);
      cycle();
    end
    idle_in();

    // BN full tile of 16 rows, then one extra write into DRAIN
    ifc.buf_input_select = 1; ifc.buf_output_select = 1;
    ifc.inp_ready = 0; ifc.wp_ready = 0;
    got.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ifc.bn_valid = 1; ifc.bn_data = 64'h0123_0456_0789_0000 + 64'(i);
      ifc.sa_valid = 1; ifc.sa_data = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
    end
    chk("full_count", ifc.word_count, 5'd16);
    chk("full_wp_valid", ifc.wp_valid, 1'b1);
    chk("full_ovf_before", ifc.overflow_err, 1'b0);
    ifc.sa_valid = 0; ifc.bn_valid = 1; ifc.bn_data = 64'h0555_0555_0555_0555;
    cycle();
    idle_in();
    ifc.wr_last = 1; cycle(); ifc.wr_last = 0;
    chk("full_ovf", ifc.overflow_err, 1'b1);
    chk("full_count_held", ifc.word_count, 5'd16);
    drain_all(1'b0, 1'b1);
    chk("full_drained", ROW_W'(got.size()), ROW_W'(DEPTH));
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      chk("full_row", got[i], 64'h0123_0456_0789_0000 + 64'(i));

    // Stall: 4 SA rows to the weight prefetcher with ready 0/1/0/0/1
    ifc.buf_input_select = 0; ifc.buf_output_select = 1;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      ifc.sa_valid = 1; ifc.sa_data = 64'hA000_0000_0000_0000 + 64'(i);
      ifc.wr_last = (i == 3);
      cycle();
    end
    idle_in();
    stall_pat = 5'b10010;
    prev_stall = 0; prev_d = '0;
    for (int k = 0; k < 40 && ifc.buf_busy; k++) begin
      ifc.wp_ready = stall_pat[k % 5];
      ifc.inp_ready = 1;
      if (prev_stall) chk("stall_data_stable", ifc.wp_data, prev_d);
      prev_stall = ifc.wp_valid && !ifc.wp_ready;
      prev_d = ifc.wp_data;
      cycle();
    end
    chk("stall_done", ifc.buf_busy, 1'b0);
    chk("stall_rows", ROW_W'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("stall_row", got[i], 64'hA000_0000_0000_0000 + 64'(i));

    // Select changes mid-phase
    ifc.buf_input_select = 0; ifc.buf_output_select = 0;
    got.delete(); wp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ifc.buf_input_select = 1;
      ifc.sa_valid = 1; ifc.sa_data = 64'h5A00_0000_0000_0010 + 64'(i);
      ifc.bn_valid = (i >= 2); ifc.bn_data = 64'h0BAD_0BAD_0BAD_0BAD;
      ifc.wr_last = (i == 3);
      cycle();
    end
    idle_in();
    ifc.buf_output_select = 1;
    drain_all(1'b1, 1'b1);
    chk("selchg_no_wp", wp_seen, 1'b0);
    chk("selchg_rows", ROW_W'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("selchg_row", got[i], 64'h5A00_0000_0000_0010 + 64'(i));

    // Asynchronous reset mid-DRAIN
    ifc.buf_input_select = 0; ifc.buf_output_select = 0;
    ifc.inp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ifc.sa_valid = 1; ifc.sa_data = 64'h0C00_0000_0000_0000 + 64'(i);
      ifc.wr_last = (i == 4);
      cycle();
    end
    idle_in();
    ifc.sa_valid = 1; ifc.inp_ready = 1; cycle();
    ifc.sa_valid = 0; cycle();
    ifc.inp_ready = 0; cycle();
    chk("pre_rst_count", ifc.word_count, 5'd3);
    chk("pre_rst_ovf", ifc.overflow_err, 1'b1);
    #2 rst = 1;
    #1;
    chk("arst_inp_valid", ifc.inp_valid, 1'b0);
    chk("arst_count", ifc.word_count, '0);
    chk("arst_ovf", ifc.overflow_err, 1'b0);
    chk("arst_busy", ifc.buf_busy, 1'b0);
    rst = 0;
    model_reset();
    got.delete();
    ifc.sa_valid = 1; ifc.sa_data = 64'h0D0D_0D0D_0D0D_0D0D; ifc.wr_last = 1;
    cycle();
    idle_in();
    drain_all(1'b1, 1'b0);
    chk("post_rst_rows", ROW_W'(got.size()), 1);
    if (got.size() > 0) chk("post_rst_row", got[0], 64'h0D0D_0D0D_0D0D_0D0D);

    // ReLU lanes through BN, then the same lanes through SA
    relu_in = 64'h7FFF_FFFF_0005_8001;
`ifdef OUT_BUF_RELU_EN
    relu_exp = 64'h7FFF_0000_0005_0000;
`else
    relu_exp = relu_in;
`endif
    got.delete();
    ifc.buf_input_select = 1; ifc.buf_output_select = 0;
    ifc.bn_valid = 1; ifc.bn_data = relu_in; ifc.wr_last = 1;
    cycle();
    idle_in();
    drain_all(1'b1, 1'b0);
    ifc.buf_input_select = 0;
    ifc.sa_valid = 1; ifc.sa_data = relu_in; ifc.wr_last = 1;
    cycle();
    idle_in();
    drain_all(1'b1, 1'b0);
    chk("relu_rows", ROW_W'(got.size()), 2);
    if (got.size() > 1) begin
      chk("relu_bn", got[0], relu_exp);
      chk("relu_sa", got[1], relu_in);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) ifc.buf_input_select = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ifc.buf_output_select = 1'($urandom_range(0, 1));
      ifc.sa_valid  = ($urandom_range(0, 2) == 0);
      ifc.bn_valid  = ($urandom_range(0, 2) == 0);
      ifc.sa_data   = {$urandom, $urandom};
      ifc.bn_data   = {$urandom, $urandom};
      ifc.wr_last   = ($urandom_range(0, 9) == 0);
      ifc.inp_ready = ($urandom_range(0, 1) == 0);
      ifc.wp_ready  = ($urandom_range(0, 1) == 0);
      cycle();
    end
    idle_in();
    drain_all(1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
